pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//   Parametrised fetch-PC generator: next generation of the single-register PC.
//   Holds the fetch PC and picks the next PC by priority: trap, redirect, return prediction, sequential.
//   Adds a fetch handshake, stall, halt/resume FSM, boot state, misalignment flag and an optional return-address stack.
//   Sits between hazard/branch/trap control and the instruction-memory fetch port (IF stage).
// PARAMETERS
//   XLEN          32          address width in bits
//   RESET_VECTOR  32'h0       PC loaded on reset
//   TRAP_VECTOR   32'h100     PC loaded on trap_i
//   ALIGN_BITS    2           forced-zero low bits: 2 = 4-byte, 1 = 2-byte instructions
//   RAS_DEPTH     4           return-address-stack entries, power of 2, >=2 (used only with PC_RAS_EN)
// PORTS
//   clk               in   1     clock
//   reset             in   1     asynchronous reset, active-high
//   stall_i           in   1     hazard stall: hold PC
//   fetch_ready_i     in   1     imem accepts pc_o this cycle
//   redirect_valid_i  in   1     branch/jump resolved: load redirect_pc_i
//   redirect_pc_i     in   XLEN  redirect target
//   trap_i            in   1     exception: load TRAP_VECTOR
//   halt_i            in   1     enter HALT (ebreak/wfi)
//   is_call_i         in   1     predecode: instruction at pc_o is a call
//   is_ret_i          in   1     predecode: instruction at pc_o is a return
//   pc_o              out  XLEN  current fetch PC
//   pc_valid_o        out  1     pc_o valid for fetch
//   pc_inc_o          out  XLEN  pc_o + 2**ALIGN_BITS, modulo 2**XLEN
//   misalign_o        out  1     1-cycle pulse: redirect target had nonzero low bits
//   halted_o          out  1     FSM in HALT
// BEHAVIOUR
//   Reset (async): pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, halted_o=0, state=BOOT, RAS empty.
//   FSM: BOOT -> RUN after exactly one clk edge with reset low; pc_valid_o=0 in BOOT.
//        RUN -> HALT on halt_i, unless trap_i or redirect_valid_i is also asserted.
//        HALT -> RUN on trap_i or redirect_valid_i, loading that target; HALT ignores stall/ready.
//   pc_valid_o=1 only in RUN. halted_o=1 only in HALT.
//   advance = RUN & pc_valid_o & fetch_ready_i & ~stall_i.
//   Next-PC priority, evaluated each edge in RUN/HALT:
//     1 trap_i           -> TRAP_VECTOR (overrides stall, ready, halt)
//     2 redirect_valid_i -> {redirect_pc_i[XLEN-1:ALIGN_BITS], 0s} (overrides stall, ready)
//     3 ~advance         -> hold pc_o
//     4 advance & is_ret_i & RAS nonempty -> RAS top, pop (PC_RAS_EN only)
//     5 advance          -> pc_inc_o
//   Trap and redirect both asserted: trap wins; redirect is dropped and misalign_o is not raised.
//   misalign_o=1 for the edge after an accepted redirect with redirect_pc_i[ALIGN_BITS-1:0]!=0; PC is still aligned down.
//   Sequential wrap: max aligned address + increment -> 0, no flag.
//   Every path to pc_o keeps bits [ALIGN_BITS-1:0]==0.
//   Latency: next PC appears on pc_o one cycle after the decision edge; no combinational path from inputs to pc_o.
//   Reset mid-operation: immediate async return to BOOT/RESET_VECTOR; RAS cleared.
//   BOOT ignores all inputs, including trap_i.
// CONFIGURATION
//   PC_RAS_EN defined:
//     Circular RAS of RAS_DEPTH entries.
//     advance & is_call_i pushes pc_inc_o. When full, the push overwrites the oldest entry; count saturates at RAS_DEPTH.
//     advance & is_ret_i pops when nonempty. Empty pop falls through to sequential.
//     Same-cycle call and ret: pop first, then push pc_inc_o; top is replaced and count is unchanged.
//     trap_i clears the RAS. redirect_valid_i leaves it unchanged.
//   PC_RAS_EN undefined:
//     No RAS storage; is_call_i and is_ret_i are ignored; priority 4 is absent.
// TESTING
//   T1 reset, release -> cycle 1 pc_o=0 valid=0; cycle 2 valid=1; then 0,4,8 with fetch_ready_i=1.
//   T2 stall_i=1 at pc=0x8 for 3 cycles -> pc_o stays 0x8; redirect 0x40 during stall -> pc_o=0x40 next cycle.
//   T3 trap_i and redirect_valid_i (0x80) in same cycle -> pc_o=0x100, misalign_o=0; redirect 0x42 -> pc_o=0x40, misalign_o pulses 1 cycle.
//   T4 halt_i -> halted_o=1, valid=0, PC held despite ready; redirect 0x200 -> RUN, pc_o=0x200.
//   T5 pc=0xFFFF_FFFC, advance -> pc_o=0x0000_0000.
//   T6 (PC_RAS_EN) calls at 0x10,0x20,0x30,0x40,0x50 (depth 4), then 5 rets -> 0x54,0x44,0x34,0x24, then sequential.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Fetch-PC generator: BOOT/RUN/HALT control, prioritised next-PC select and misalignment flag.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              ALIGN_BITS   = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic            halt_i,
    input  logic            is_call_i,
    input  logic            is_ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_inc_o,
    output logic            misalign_o,
    output logic            halted_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};
    localparam logic [XLEN-1:0] INC        = XLEN'(1) << ALIGN_BITS;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            advance;
    logic            seq_ok;
    logic            ret_hit;
    logic [XLEN-1:0] ras_top;

    assign advance    = (state_q == RUN) & fetch_ready_i & ~stall_i;
    // RAS activity only when neither trap nor redirect claims the edge.
    assign seq_ok     = advance & ~trap_i & ~redirect_valid_i;
    assign pc_o       = pc_q;
    assign pc_inc_o   = pc_q + INC;
    assign pc_valid_o = (state_q == RUN);
    assign halted_o   = (state_q == HALT);
    assign misalign_o = misalign_q;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, sp_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop, do_push;

    assign sp_dec  = sp_q - PTR_W'(1);
    assign ras_top = ras_q[sp_dec];
    assign ret_hit = is_ret_i & (cnt_q != '0);
    assign do_pop  = seq_ok & ret_hit;
    assign do_push = seq_ok & is_call_i;

    always_comb begin
        ras_d = ras_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (state_q != BOOT && trap_i) begin
            sp_d  = '0;
            cnt_d = '0;
        end else if (do_pop && do_push) begin
            ras_d[sp_dec] = pc_inc_o;
        end else if (do_pop) begin
            sp_d  = sp_dec;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (do_push) begin
            // Circular buffer: a push when full silently overwrites the oldest entry.
            ras_d[sp_q] = pc_inc_o;
            sp_d        = sp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = is_call_i ^ is_ret_i;
    assign ret_hit           = 1'b0;
    assign ras_top           = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HALT: begin
                if (trap_i) begin
                    pc_d    = TRAP_VECTOR & ~ALIGN_MASK;
                    state_d = RUN;
                end else if (redirect_valid_i) begin
                    pc_d       = redirect_pc_i & ~ALIGN_MASK;
                    misalign_d = |(redirect_pc_i & ALIGN_MASK);
                    state_d    = RUN;
                end else begin
                    if (state_q == RUN && halt_i) state_d = HALT;
                    if (advance) pc_d = ret_hit ? (ras_top & ~ALIGN_MASK) : pc_inc_o;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR & ~ALIGN_MASK;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: reset/boot, stall, trap vs redirect, halt, wrap, and RAS (PC_RAS_EN).
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, fetch_ready_i, redirect_valid_i, trap_i, halt_i, is_call_i, is_ret_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, pc_inc_o;
  logic        pc_valid_o, misalign_o, halted_o;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen_unit dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i), .trap_i(trap_i),
    .halt_i(halt_i), .is_call_i(is_call_i), .is_ret_i(is_ret_i), .pc_o(pc_o),
    .pc_valid_o(pc_valid_o), .pc_inc_o(pc_inc_o), .misalign_o(misalign_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall_i = 0; redirect_valid_i = 0; trap_i = 0; halt_i = 0;
    is_call_i = 0; is_ret_i = 0; redirect_pc_i = '0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid_i = 1; redirect_pc_i = tgt;
    tick();
    redirect_valid_i = 0;
  endtask

  initial begin
    clear_ctl();
    fetch_ready_i = 1;
    reset = 1;
    #12;
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'b0, pc_valid_o}, 32'd0);
    check("rst_misalign", {31'b0, misalign_o}, 32'd0);
    check("rst_halted", {31'b0, halted_o}, 32'd0);
    @(negedge clk);
    reset = 0;

    // T1: BOOT cycle ignores trap, then sequential 0,4,8
    trap_i = 1;
    check("boot_pc", pc_o, 32'h0);
    check("boot_valid", {31'b0, pc_valid_o}, 32'd0);
    tick();
    trap_i = 0;
    check("run_valid", {31'b0, pc_valid_o}, 32'd1);
    check("run_pc0", pc_o, 32'h0);
    check("run_inc0", pc_inc_o, 32'h4);
    tick(); check("seq_pc4", pc_o, 32'h4);
    tick(); check("seq_pc8", pc_o, 32'h8);

    // T2: stall holds, redirect overrides stall
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", pc_o, 32'h8);
    end
    redirect(32'h40);
    check("redir_stall_pc", pc_o, 32'h40);
    check("redir_stall_mis", {31'b0, misalign_o}, 32'd0);
    stall_i = 0;
    fetch_ready_i = 0;
    tick(); check("not_ready_hold", pc_o, 32'h40);
    fetch_ready_i = 1;
    tick(); check("seq_pc44", pc_o, 32'h44);

    // T3: trap beats redirect; misaligned redirect pulses flag
    trap_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h81;
    tick();
    clear_ctl();
    check("trap_pc", pc_o, 32'h100);
    check("trap_mis", {31'b0, misalign_o}, 32'd0);
    redirect(32'h42);
    check("mis_pc", pc_o, 32'h40);
    check("mis_pulse", {31'b0, misalign_o}, 32'd1);
    fetch_ready_i = 0;
    tick();
    check("mis_clear", {31'b0, misalign_o}, 32'd0);
    check("mis_hold", pc_o, 32'h40);
    fetch_ready_i = 1;

    // T4: halt holds PC despite ready; redirect resumes
    halt_i = 1; stall_i = 1;
    tick();
    halt_i = 0; stall_i = 0;
    check("halt_halted", {31'b0, halted_o}, 32'd1);
    check("halt_valid", {31'b0, pc_valid_o}, 32'd0);
    check("halt_pc", pc_o, 32'h40);
    tick(); check("halt_hold", pc_o, 32'h40);
    check("halt_stays", {31'b0, halted_o}, 32'd1);
    redirect(32'h200);
    check("resume_pc", pc_o, 32'h200);
    check("resume_halted", {31'b0, halted_o}, 32'd0);
    check("resume_valid", {31'b0, pc_valid_o}, 32'd1);
    tick(); check("resume_seq", pc_o, 32'h204);
    halt_i = 1; redirect(32'h300);
    halt_i = 0;
    check("halt_redir_pc", pc_o, 32'h300);
    check("halt_redir_run", {31'b0, halted_o}, 32'd0);
    halt_i = 1; stall_i = 1;
    tick();
    halt_i = 0; stall_i = 0;
    trap_i = 1;
    tick();
    trap_i = 0;
    check("halt_trap_pc", pc_o, 32'h100);
    check("halt_trap_valid", {31'b0, pc_valid_o}, 32'd1);

    // T5: sequential wrap
    redirect(32'hFFFF_FFFC);
    check("wrap_pre", pc_o, 32'hFFFF_FFFC);
    check("wrap_inc", pc_inc_o, 32'h0);
    tick();
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_mis", {31'b0, misalign_o}, 32'd0);

`ifdef PC_RAS_EN
    // T6: five calls into a 4-deep stack, then returns
    for (int i = 1; i <= 5; i++) begin
      redirect(32'(i * 16));
      is_call_i = 1; tick(); is_call_i = 0;
      check("call_seq", pc_o, 32'(i * 16 + 4));
    end
    is_ret_i = 1;
    tick(); check("ret1", pc_o, 32'h54);
    tick(); check("ret2", pc_o, 32'h44);
    tick(); check("ret3", pc_o, 32'h34);
    tick(); check("ret4", pc_o, 32'h24);
    tick(); check("ret_empty", pc_o, 32'h28);
    is_ret_i = 0; is_call_i = 1;
    tick(); check("call_2c", pc_o, 32'h2C);
    is_ret_i = 1;
    tick(); check("callret_pop", pc_o, 32'h2C);
    is_call_i = 0;
    tick(); check("callret_top", pc_o, 32'h30);
    tick(); check("callret_empty", pc_o, 32'h34);
    is_ret_i = 0; is_call_i = 1;
    tick(); check("call_38", pc_o, 32'h38);
    is_call_i = 0; trap_i = 1;
    tick(); trap_i = 0;
    is_ret_i = 1;
    tick(); check("trap_cleared_ras", pc_o, 32'h104);
    is_ret_i = 0;
`else
    // Without the RAS, call/ret hints are ignored
    is_call_i = 1; is_ret_i = 1;
    tick(); check("noras_callret", pc_o, 32'h4);
    is_call_i = 0;
    tick(); check("noras_ret", pc_o, 32'h8);
    is_ret_i = 0;
`endif

    // Mid-operation async reset
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("async_rst_pc", pc_o, 32'h0);
    check("async_rst_valid", {31'b0, pc_valid_o}, 32'd0);
    @(negedge clk);
    reset = 0;
    tick();
    check("rerun_valid", {31'b0, pc_valid_o}, 32'd1);
    tick();
    check("rerun_pc", pc_o, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
